aurora_bus_arbiter: RTL and testbench
=====================================

// Module: aurora_bus_arbiter
// PURPOSE
//  Shares the single Aurora FPGA local bus (stb/we/ack, dat_o/dat_i) between two write requesters
//  (req_w_1, req_w_2) and two read requesters (req_r_1, req_r_2). Round-robin grant, bounded bursts,
//  ack-timeout abort. Sits between the requester FIFOs and the Aurora slave port; drives the signals
//  probed by the debug ILA.
// PARAMETERS
//  DATA_W     32    bus data width
//  BURST_LEN  16    max words per grant (>=1)
//  TIMEOUT    1023  cycles of stb without ack before abort (>=1)
//  TO_W       10    timeout counter width, 2**TO_W > TIMEOUT
// PORTS
//  clk       in   1       single clock
//  rst       in   1       async reset, active-high
//  req_w_1   in   1       write requester 1 request (level; held for whole burst)
//  req_w_2   in   1       write requester 2 request
//  req_r_1   in   1       read requester 1 request
//  req_r_2   in   1       read requester 2 request
//  wdat_1    in   DATA_W  write data from requester 1 (current word)
//  wdat_2    in   DATA_W  write data from requester 2
//  gnt       out  4       one-hot grant {r2,r1,w2,w1}
//  wnext     out  1       pulse: granted writer's word accepted, present next word
//  rdat      out  DATA_W  registered read data to granted reader
//  rvld      out  1       pulse: rdat valid for granted reader
//  s_rdy     in   1       slave ready; stb only asserted while high
//  stb       out  1       bus strobe
//  we        out  1       1=write, 0=read; valid with stb
//  dat_o     out  DATA_W  write data (muxed wdat_x of granted writer)
//  ack       in   1       slave accepts word when stb&ack
//  dat_i     in   DATA_W  read data, valid with stb&ack&!we
//  abort     out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; RR pointer -> w1; counters 0. rst mid-burst drops stb/gnt at once.
//  States: IDLE -> XFER -> IDLE | ABORT -> IDLE.
//  IDLE: any req high at edge N -> gnt one-hot registered at N+1, state XFER; winner = first requester
//   at/after RR pointer in order w1,w2,r1,r2.
//  XFER: stb = s_rdy (combinational from registered state); we = gnt[w1]|gnt[w2]; dat_o = granted wdat.
//   stb&ack = one word: wnext pulses same cycle (writes); rdat<=dat_i, rvld=1 next cycle (reads);
//   word count increments.
//  XFER exit to IDLE (gnt=0 next cycle, pointer = winner+1 mod 4) when: acked word is BURST_LEN-th, or
//   granted req low with no ack this cycle. req drop coinciding with ack: word counts, then release.
//  Timeout counter: increments each XFER cycle with stb&!ack, clears on ack or s_rdy low.
//   Reaching TIMEOUT -> ABORT: stb=0, gnt=0, abort=1 for exactly one cycle, pointer advanced past
//   winner, then IDLE. Requester must re-request.
//  Min gap between bursts: one IDLE cycle (no back-to-back grants). Counters never wrap: count <= BURST_LEN.
// CONFIGURATION
//  AURORA_ARB_WR_PRIO_EN defined: writers strictly over readers; RR (w1,w2) among writers, RR (r1,r2)
//   among readers, independent pointers. Undefined: flat 4-way RR as above. Ports identical.
// STRUCTURE
//  Package aurora_arb_pkg: state enum (IDLE,XFER,ABORT), requester indices (W1=0,W2=1,R1=2,R2=3),
//   NREQ=4, grant one-hot type.
//  Sub-module aurora_arb_rr_pick: combinational pointer+req -> one-hot winner; instantiated once
//   (twice with AURORA_ARB_WR_PRIO_EN).
// TESTING
//  req_w_1 held, s_rdy=1, ack every cycle, wdat_1=0x1000+n -> gnt=0001 one cycle after req, 16 wnext,
//   dat_o 0x1000..0x100F, release, 1 IDLE cycle.
//  All four req high continuously -> grant order w1,w2,r1,r2,w1 (flat); with AURORA_ARB_WR_PRIO_EN ->
//   w1,w2,w1,w2, readers starved.
//  req_r_2 alone, dat_i=0xCAFE0000+n with ack every other cycle -> 16 rvld, rdat matches, we=0 throughout.
//  Granted writer, ack never asserted -> abort pulse exactly TIMEOUT cycles after first stb, gnt=0,
//   next grant goes to following requester.
//  req_w_2 drops in the same cycle as 5th ack -> 5 words counted, gnt=0 next cycle, pointer -> r1.
//  rst asserted mid-burst (word 7) -> stb,gnt,wnext,rvld 0 immediately; after release first grant is w1.

Source files
------------

// File: rtl/aurora_arb_pkg.sv
// Shared types for the Aurora local-bus arbiter: FSM states, requester indices, grant vector.
package aurora_arb_pkg;

    typedef enum logic [1:0] {StIdle, StXfer, StAbort} state_e;

    localparam int unsigned NREQ = 4;
    localparam int unsigned W1   = 0;
    localparam int unsigned W2   = 1;
    localparam int unsigned R1   = 2;
    localparam int unsigned R2   = 3;

    typedef logic [NREQ-1:0] gnt_t;

    function automatic logic [1:0] gnt_idx(gnt_t g);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (g[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/aurora_arb_rr_pick.sv
// Combinational round-robin picker: first request at or after the pointer wins (one-hot out).
module aurora_arb_rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned PtrW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [PtrW-1:0] ptr_i,
    input  logic [N-1:0]    req_i,
    output logic [N-1:0]    gnt_o
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PtrW'((32'(ptr_i) + i) % N);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/aurora_bus_arbiter.sv
// Round-robin arbiter for the Aurora local bus: 2 writers, 2 readers, bounded bursts, ack timeout.
// Define AURORA_ARB_WR_PRIO_EN for strict writer-over-reader priority with separate RR pointers.
module aurora_bus_arbiter
    import aurora_arb_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned TIMEOUT   = 1023,
    parameter int unsigned TO_W      = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_w_1,
    input  logic              req_w_2,
    input  logic              req_r_1,
    input  logic              req_r_2,
    input  logic [DATA_W-1:0] wdat_1,
    input  logic [DATA_W-1:0] wdat_2,
    output logic [3:0]        gnt,
    output logic              wnext,
    output logic [DATA_W-1:0] rdat,
    output logic              rvld,
    input  logic              s_rdy,
    output logic              stb,
    output logic              we,
    output logic [DATA_W-1:0] dat_o,
    input  logic              ack,
    input  logic [DATA_W-1:0] dat_i,
    output logic              abort
);

    localparam int unsigned CntW = $clog2(BURST_LEN + 1);

    state_e            state_q, state_d;
    gnt_t              gnt_q, gnt_d, pick, req;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              rvld_q, rvld_d;
    logic              acc, req_g, last, advance;

    assign req = {req_r_2, req_r_1, req_w_2, req_w_1};

`ifdef AURORA_ARB_WR_PRIO_EN
    logic       wptr_q, wptr_d, rptr_q, rptr_d;
    logic [1:0] wpick, rpick;

    aurora_arb_rr_pick #(.N(2)) u_pick_w (.ptr_i(wptr_q), .req_i(req[W2:W1]), .gnt_o(wpick));
    aurora_arb_rr_pick #(.N(2)) u_pick_r (.ptr_i(rptr_q), .req_i(req[R2:R1]), .gnt_o(rpick));

    // Any pending writer blocks all readers.
    assign pick = (|req[W2:W1]) ? {2'b00, wpick} : {rpick, 2'b00};
`else
    logic [1:0] ptr_q, ptr_d;

    aurora_arb_rr_pick #(.N(NREQ)) u_pick (.ptr_i(ptr_q), .req_i(req), .gnt_o(pick));
`endif

    assign stb   = (state_q == StXfer) && s_rdy;
    assign we    = gnt_q[W1] | gnt_q[W2];
    assign dat_o = gnt_q[W1] ? wdat_1 : (gnt_q[W2] ? wdat_2 : '0);
    assign acc   = stb && ack;
    assign wnext = acc && we;
    assign abort = (state_q == StAbort);
    assign gnt   = gnt_q;
    assign rdat  = rdat_q;
    assign rvld  = rvld_q;
    assign req_g = |(req & gnt_q);
    assign last  = (cnt_q == CntW'(BURST_LEN - 1));

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        to_d    = to_q;
        rdat_d  = rdat_q;
        rvld_d  = 1'b0;
        advance = 1'b0;
        if (acc && !we) begin
            rdat_d = dat_i;
            rvld_d = 1'b1;
        end
        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                to_d  = '0;
                if (|req) begin
                    gnt_d   = pick;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                if (acc) begin
                    cnt_d = cnt_q + CntW'(1);
                    to_d  = '0;
                end else if (stb) begin
                    to_d = to_q + TO_W'(1);
                end else begin
                    to_d = '0;
                end
                // A requester dropping on an acked word still gets that word counted.
                if ((acc && last) || !req_g) begin
                    state_d = StIdle;
                    gnt_d   = '0;
                    advance = 1'b1;
                end else if (stb && !ack && (to_q == TO_W'(TIMEOUT - 1))) begin
                    state_d = StAbort;
                    gnt_d   = '0;
                    advance = 1'b1;
                end
            end
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

`ifdef AURORA_ARB_WR_PRIO_EN
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (advance) begin
            if (we) wptr_d = gnt_q[W1];
            else    rptr_d = gnt_q[R1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= 1'b0;
            rptr_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end
`else
    always_comb begin
        ptr_d = ptr_q;
        if (advance) ptr_d = gnt_idx(gnt_q) + 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= 2'd0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            gnt_q   <= '0;
            cnt_q   <= '0;
            to_q    <= '0;
            rdat_q  <= '0;
            rvld_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            to_q    <= to_d;
            rdat_q  <= rdat_d;
            rvld_q  <= rvld_d;
        end
    end

endmodule

// File: tb/tb_aurora_bus_arbiter.sv
// Scoreboard bench for aurora_bus_arbiter; honours AURORA_ARB_WR_PRIO_EN for the grant-order case.
module tb_aurora_bus_arbiter;

    localparam int TO = 1023;

    logic        clk, rst;
    logic        req_w_1, req_w_2, req_r_1, req_r_2;
    logic [31:0] wdat_1, wdat_2, rdat, dat_o, dat_i;
    logic [3:0]  gnt;
    logic        wnext, rvld, s_rdy, stb, we, ack, abort;

    aurora_bus_arbiter #(
        .DATA_W(32), .BURST_LEN(16), .TIMEOUT(TO), .TO_W(10)
    ) dut (
        .clk(clk), .rst(rst),
        .req_w_1(req_w_1), .req_w_2(req_w_2), .req_r_1(req_r_1), .req_r_2(req_r_2),
        .wdat_1(wdat_1), .wdat_2(wdat_2),
        .gnt(gnt), .wnext(wnext), .rdat(rdat), .rvld(rvld),
        .s_rdy(s_rdy), .stb(stb), .we(we), .dat_o(dat_o),
        .ack(ack), .dat_i(dat_i), .abort(abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ack_mode = 0;  // 0 never, 1 every cycle, 2 every other cycle
    bit tog = 1'b0;
    int lim[4];
    int n[4];
    logic [3:0] reqv;
    logic [3:0] prev_gnt = 4'd0;

    logic [3:0]  exp_gnt_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] exp_r_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    // Requester models: n[i] words accepted; request drops together with the lim-th ack.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) n[i] <= 0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (gnt[i] && stb && ack) n[i] <= n[i] + 1;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++)
            reqv[i] = (n[i] < lim[i]) && !((n[i] == lim[i] - 1) && gnt[i] && stb && ack);
    end

    assign {req_r_2, req_r_1, req_w_2, req_w_1} = reqv;
    assign ack    = (ack_mode == 1) || (ack_mode == 2 && tog);
    assign wdat_1 = 32'h0000_1000 + 32'(n[0]);
    assign wdat_2 = 32'h0000_2000 + 32'(n[1]);
    assign dat_i  = 32'hCAFE_0000 + 32'(n[2] + n[3]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops expected grants/words whenever the DUT presents them.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 4'd0 && prev_gnt == 4'd0) begin
                if (exp_gnt_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_grant: got %b expected none", gnt);
                end else chk("grant_order", 32'(gnt), 32'(exp_gnt_q.pop_front()));
            end
            if (wnext) begin
                if (exp_w_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_write: got %h expected none", dat_o);
                end else chk("write_data", dat_o, exp_w_q.pop_front());
            end
            if (rvld) begin
                if (exp_r_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_read: got %h expected none", rdat);
                end else chk("read_data", rdat, exp_r_q.pop_front());
            end
        end
        prev_gnt <= gnt;
    end

    task automatic do_reset();
        rst = 1'b1;
        ack_mode = 0;
        s_rdy = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_ctl", 32'({stb, we, wnext, rvld, abort}), 32'd0);
        chk("rst_data", rdat | dat_o, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_gnt(input logic [3:0] v, input int maxc, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < maxc && !hit; k++) begin
            @(posedge clk);
            #1;
            if (gnt == v) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: got gnt=%b expected %b within %0d cycles", name, gnt, v, maxc);
        end
    endtask

    task automatic wait_drain(input int maxc, input string name);
        bit hit = 1'b0;
        for (int k = 0; k < maxc && !hit; k++) begin
            @(posedge clk);
            #1;
            if (gnt == 4'd0 && exp_gnt_q.size() == 0 && exp_w_q.size() == 0 &&
                exp_r_q.size() == 0) hit = 1'b1;
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: got pending g=%0d w=%0d r=%0d expected all drained", name,
                     exp_gnt_q.size(), exp_w_q.size(), exp_r_q.size());
        end
    endtask

    initial begin
        int c1, c2, we_err;
        rst = 1'b1;
        s_rdy = 1'b1;
        for (int i = 0; i < 4; i++) lim[i] = 0;

        // Single writer: two full bursts separated by exactly one idle cycle.
        do_reset();
        ack_mode = 1;
        lim[0] = 32;
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0001);
        for (int k = 0; k < 32; k++) exp_w_q.push_back(32'h1000 + 32'(k));
        @(posedge clk);
        #1;
        chk("t1_gnt_latency", 32'(gnt), 32'b0001);
        wait_gnt(4'd0, 40, "t1_release");
        chk("t1_burst_words", 32'(n[0]), 32'd16);
        @(posedge clk);
        #1;
        chk("t1_one_idle_gap", 32'(gnt), 32'b0001);
        wait_drain(40, "t1_drain");

        // All four requesting continuously.
        do_reset();
        ack_mode = 1;
`ifdef AURORA_ARB_WR_PRIO_EN
        lim[0] = 32; lim[1] = 32; lim[2] = 16; lim[3] = 16;
        exp_gnt_q = '{4'b0001, 4'b0010, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 16; k++) exp_w_q.push_back(32'h1000 + 32'(16 * b + k));
            for (int k = 0; k < 16; k++) exp_w_q.push_back(32'h2000 + 32'(16 * b + k));
        end
`else
        lim[0] = 32; lim[1] = 16; lim[2] = 16; lim[3] = 16;
        exp_gnt_q = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int k = 0; k < 16; k++) exp_w_q.push_back(32'h1000 + 32'(k));
        for (int k = 0; k < 16; k++) exp_w_q.push_back(32'h2000 + 32'(k));
        for (int k = 16; k < 32; k++) exp_w_q.push_back(32'h1000 + 32'(k));
`endif
        for (int k = 0; k < 32; k++) exp_r_q.push_back(32'hCAFE_0000 + 32'(k));
        wait_drain(400, "t2_drain");

        // Lone reader with ack every other cycle.
        do_reset();
        ack_mode = 2;
        lim[3] = 16;
        exp_gnt_q.push_back(4'b1000);
        for (int k = 0; k < 16; k++) exp_r_q.push_back(32'hCAFE_0000 + 32'(k));
        we_err = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (stb && we) we_err++;
            if (k > 2 && gnt == 4'd0 && exp_r_q.size() == 0) break;
        end
        chk("t3_we_low", 32'(we_err), 32'd0);
        chk("t3_read_words", 32'(n[3]), 32'd16);
        chk("t3_reads_left", 32'(exp_r_q.size()), 32'd0);

        // Ack never comes: abort after TIMEOUT stb cycles, then the next requester wins.
        do_reset();
        ack_mode = 0;
        lim[0] = 1; lim[1] = 1;
        exp_gnt_q.push_back(4'b0001);
        exp_gnt_q.push_back(4'b0010);
        c1 = 0; c2 = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (stb) begin c1 = cyc; break; end
        end
        for (int k = 0; k < TO + 50; k++) begin
            @(posedge clk);
            #1;
            if (abort) begin c2 = cyc; break; end
        end
        chk("t4_abort_delay", 32'(c2 - c1), 32'(TO));
        chk("t4_abort_gnt", 32'(gnt), 32'd0);
        chk("t4_abort_stb", 32'(stb), 32'd0);
        @(posedge clk);
        #1;
        chk("t4_abort_pulse", 32'(abort), 32'd0);
        wait_gnt(4'b0010, 5, "t4_next_grant");
        lim[0] = 0; lim[1] = 0;
        wait_drain(5, "t4_drain");

        // Writer 2 drops together with its 5th ack; pointer moves on to r1.
        do_reset();
        ack_mode = 1;
        lim[1] = 5;
        exp_gnt_q.push_back(4'b0010);
        for (int k = 0; k < 5; k++) exp_w_q.push_back(32'h2000 + 32'(k));
        wait_gnt(4'b0010, 5, "t5_grant");
        repeat (5) @(posedge clk);
        #1;
        chk("t5_release", 32'(gnt), 32'd0);
        chk("t5_words", 32'(n[1]), 32'd5);
        ack_mode = 0;
        lim[0] = 1; lim[2] = 1;
        exp_gnt_q.push_back(4'b0100);
        wait_gnt(4'b0100, 5, "t5_ptr_r1");
        lim[0] = 0; lim[2] = 0;
        wait_drain(5, "t5_drain");

        // Reset during the 7th word of a burst.
        do_reset();
        ack_mode = 1;
        lim[0] = 32;
        exp_gnt_q.push_back(4'b0001);
        for (int k = 0; k < 6; k++) exp_w_q.push_back(32'h1000 + 32'(k));
        for (int k = 0; k < 30; k++) begin
            @(posedge clk);
            #1;
            if (n[0] == 6) break;
        end
        chk("t6_in_word7", 32'({wnext, n[0] == 6}), 32'b11);
        #1;
        rst = 1'b1;
        #1;
        chk("t6_rst_gnt", 32'(gnt), 32'd0);
        chk("t6_rst_ctl", 32'({stb, wnext, rvld}), 32'd0);
        ack_mode = 0;
        lim[1] = 1;
        exp_gnt_q.push_back(4'b0001);
        @(posedge clk);
        #1;
        rst = 1'b0;
        wait_gnt(4'b0001, 5, "t6_first_grant_w1");
        lim[0] = 0; lim[1] = 0;
        wait_drain(5, "t6_drain");

        chk("end_gnt_q", 32'(exp_gnt_q.size()), 32'd0);
        chk("end_w_q", 32'(exp_w_q.size()), 32'd0);
        chk("end_r_q", 32'(exp_r_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
